line_window_3x3: RTL
====================

Name: line_window_3x3

Overview:
- Reader side of the 2-tap line buffer.
- Takes the live pixel plus the line buffer's two tap outputs, assembles a 3x3 pixel window, and tracks row and column position.
- Emits one window per interior pixel with a valid strobe, for downstream 3x3 kernels (Sobel, median, Gaussian).
- Sits directly after the line buffer, and is fed by the same pixel stream and valid signal that drive it.

Parameters:
- DATA_WIDTH, 8, pixel bit width; must match the line buffer.
- IMG_WIDTH, 400, pixels per row; must match the line buffer depth.
- IMG_HEIGHT, 300, rows per frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- dat_in  input  DATA_WIDTH  live pixel (current row).
- dat_in_valid  input  1  pixel-accept strobe; the same signal drives the line buffer CE.
- sof  input  1  start of frame; qualifies the pixel on dat_in with dat_in_valid=1.
- taps1x  input  DATA_WIDTH  line buffer output, 1 row earlier, same column as dat_in.
- taps0x  input  DATA_WIDTH  line buffer output, 2 rows earlier, same column as dat_in.
- win_00..win_22  output  DATA_WIDTH each  window pixels, win_<rowoffset><coloffset>:
  - row 0 = oldest row, col 0 = leftmost pixel;
  - win_11 is the centre.
- win_valid  output  1  one-cycle strobe; window outputs are valid.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all window outputs, win_valid and frame_done go to 0;
  - col/row counters go to 0;
  - state goes to S_IDLE.
- Interface contract: taps1x/taps0x are cycle-aligned with dat_in, i.e. they hold the same column from the two previous rows.
- Column shift registers: three rows of 3-deep registers, shifted only when dat_in_valid=1 and state is not S_IDLE.
  - Bottom row loads dat_in.
  - Middle row loads taps1x.
  - Top row loads taps0x.
  - New samples enter at column 2; older samples move toward column 0.
- States:
  - S_IDLE: wait for sof with dat_in_valid. Pixels without sof are ignored (no shift, no count).
  - S_FILL: rows 0-1; no windows produced.
  - S_RUN: rows 2..IMG_HEIGHT-1.
- Transitions:
  - S_IDLE -> S_FILL when sof and dat_in_valid; that pixel is (row 0, col 0).
  - S_FILL -> S_RUN when pixel (1, IMG_WIDTH-1) is accepted.
  - S_RUN -> S_IDLE when pixel (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
- Counters:
  - col wraps IMG_WIDTH-1 -> 0 and increments row on wrap.
  - Counter widths are $clog2 of the respective parameter.
- win_valid rules:
  - Registered; asserted the cycle after accepting pixel (r,c) with r>=2 and c>=2.
  - The window is then centred at (r-1, c-1).
  - Latency: 1 clk from the accepting edge.
  - Windows per frame = (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- Row boundaries:
  - At c=0 and c=1, win_valid stays 0.
  - Shift registers still shift, so left-edge pixels flush the previous row's right edge.
  - No window ever spans two rows.
- frame_done: pulses 1 clk after the final pixel is accepted, coincident with the final win_valid.
- sof in S_FILL/S_RUN:
  - abandons the frame; no frame_done;
  - counters restart with this pixel as (0,0); state -> S_FILL.
- Gaps: dat_in_valid=0 holds all registers and counters; win_valid=0 in those cycles.
- dat_in_valid=1 in S_IDLE without sof: ignored.
- No arithmetic on pixel data; values pass through unmodified.

Optional Feature:
- Macro: LINE_WINDOW_POS_OUT_EN.
- Defined:
  - adds outputs win_row ($clog2(IMG_HEIGHT) bits) and win_col ($clog2(IMG_WIDTH) bits);
  - both are registered alongside win_valid and give the centre coordinate (r-1, c-1);
  - both reset to 0 and hold between strobes.
- Undefined: those ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package img_proc_pkg holds:
  - DATA_WIDTH default;
  - state encodings S_IDLE=2'd0, S_FILL=2'd1, S_RUN=2'd2.
- One sub-module, window_row_shift: a 3-deep DATA_WIDTH shift register with enable and synchronous reset. It is instantiated three times (top, middle, bottom).

Test Plan:
- Bench setup: IMG_WIDTH=8, IMG_HEIGHT=6, behavioural line buffer model, pixel value = row*16+col.
- One full frame, continuous valid -> first win_valid 1 clk after pixel (2,2), with:
  - win_00=0x00, win_11=0x11, win_22=0x22, win_02=0x02;
  - exactly 24 win_valid pulses;
  - frame_done coincident with window centre (4,6): win_11=0x46.
- Row edge -> pixels (3,0) and (3,1) produce no win_valid; pixel (3,2) gives win_00=0x10, win_22=0x32.
- Random dat_in_valid gaps (~50%) -> same 24 windows with identical contents and order as the continuous run.
- sof mid-frame at pixel (3,4) -> no frame_done; the next 6*8 pixels yield 24 windows starting with win_11=0x11.
- rst asserted during S_RUN -> next cycle all outputs 0; pixels ignored until sof; a following full frame is correct.
- Pixels with dat_in_valid before the first sof -> no window, no counter movement.
- With LINE_WINDOW_POS_OUT_EN defined -> first strobe win_row=1, win_col=1; last strobe win_row=4, win_col=6.

Source files
------------

// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing line-buffer reader blocks:
// default pixel width and the window FSM state encodings.
package img_proc_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } win_state_t;

endpackage

// File: rtl/window_row_shift.sv
// One row of the 3x3 window: a 3-deep shift register with enable.
// New samples enter at o_q2 (rightmost column) and age toward o_q0.
module window_row_shift
  import img_proc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_dat,
  output logic [DATA_WIDTH-1:0] o_q0,
  output logic [DATA_WIDTH-1:0] o_q1,
  output logic [DATA_WIDTH-1:0] o_q2
);

  // Shift one column to the left on every enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q0 <= '0;
      o_q1 <= '0;
      o_q2 <= '0;
    end else if (i_en) begin
      o_q0 <= o_q1;
      o_q1 <= o_q2;
      o_q2 <= i_dat;
    end
  end

endmodule

// File: rtl/line_window_3x3.sv
// Reader side of a 2-tap line buffer: assembles a 3x3 window from the live
// pixel and the two line-buffer taps, tracks row/column, and strobes
// win_valid once per interior pixel.
// Optional: define LINE_WINDOW_POS_OUT_EN to add win_row/win_col outputs
// carrying the centre coordinate of each window.
//
//   state  | meaning
//   S_IDLE | waiting for sof; pixels without sof are ignored
//   S_FILL | rows 0-1 being loaded, no windows produced
//   S_RUN  | rows 2..IMG_HEIGHT-1, windows produced for c>=2
module line_window_3x3
  import img_proc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 300
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         dat_in,
  input  logic                          dat_in_valid,
  input  logic                          sof,
  input  logic [DATA_WIDTH-1:0]         taps1x,
  input  logic [DATA_WIDTH-1:0]         taps0x,
  output logic [DATA_WIDTH-1:0]         win_00,
  output logic [DATA_WIDTH-1:0]         win_01,
  output logic [DATA_WIDTH-1:0]         win_02,
  output logic [DATA_WIDTH-1:0]         win_10,
  output logic [DATA_WIDTH-1:0]         win_11,
  output logic [DATA_WIDTH-1:0]         win_12,
  output logic [DATA_WIDTH-1:0]         win_20,
  output logic [DATA_WIDTH-1:0]         win_21,
  output logic [DATA_WIDTH-1:0]         win_22,
  output logic                          win_valid,
`ifdef LINE_WINDOW_POS_OUT_EN
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
`endif
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  win_state_t  r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic          w_acc;
  logic [CW-1:0] w_pix_col;
  logic [RW-1:0] w_pix_row;
  logic          w_col_last;
  logic          w_row_last;

  // A pixel is taken while a frame is open, or when it opens one with sof.
  // sof always re-anchors the pixel at (0,0), even mid-frame.
  assign w_acc      = dat_in_valid & (sof | (r_state != S_IDLE));
  assign w_pix_col  = sof ? '0 : r_col;
  assign w_pix_row  = sof ? '0 : r_row;
  assign w_col_last = (w_pix_col == COL_LAST);
  assign w_row_last = (w_pix_row == ROW_LAST);

  // Top row is the oldest line (taps0x), bottom row is the live pixel.
  window_row_shift #(.DATA_WIDTH(DATA_WIDTH)) u_row_top (
    .clk(clk), .rst(rst), .i_en(w_acc), .i_dat(taps0x),
    .o_q0(win_00), .o_q1(win_01), .o_q2(win_02)
  );

  window_row_shift #(.DATA_WIDTH(DATA_WIDTH)) u_row_mid (
    .clk(clk), .rst(rst), .i_en(w_acc), .i_dat(taps1x),
    .o_q0(win_10), .o_q1(win_11), .o_q2(win_12)
  );

  window_row_shift #(.DATA_WIDTH(DATA_WIDTH)) u_row_bot (
    .clk(clk), .rst(rst), .i_en(w_acc), .i_dat(dat_in),
    .o_q0(win_20), .o_q1(win_21), .o_q2(win_22)
  );

  // FSM, position counters and registered strobes; r_col/r_row hold the
  // coordinate the next accepted pixel will occupy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef LINE_WINDOW_POS_OUT_EN
      win_row    <= '0;
      win_col    <= '0;
`endif
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (w_acc) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : w_pix_row + RW'(1);
        end else begin
          r_col <= w_pix_col + CW'(1);
          r_row <= w_pix_row;
        end

        // Columns 0 and 1 only flush the previous row out of the window.
        if (w_pix_row >= RW'(2) && w_pix_col >= CW'(2)) begin
          win_valid <= 1'b1;
`ifdef LINE_WINDOW_POS_OUT_EN
          win_row   <= w_pix_row - RW'(1);
          win_col   <= w_pix_col - CW'(1);
`endif
        end

        if (sof) begin
          r_state <= S_FILL;
        end else if (r_state == S_FILL && w_pix_row == RW'(1) && w_col_last) begin
          r_state <= S_RUN;
        end else if (r_state == S_RUN && w_row_last && w_col_last) begin
          r_state    <= S_IDLE;
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule
